// File: rtl/dose_pkg.sv
// Shared types and widths for the dose scheduler: FSM states, time-field widths,
// slot index width and the manual-request index convention.
package dose_pkg;

  typedef enum logic [1:0] {IDLE, DISPENSE, GAP} state_t;

  localparam int SLOT_IDX_W = 3;
  localparam int HOUR_W     = 5;
  localparam int MIN_W      = 6;
  localparam int SEC_W      = 6;

  // The manual request occupies the index just past the last programmable slot.
  function automatic int manual_idx(input int n_slots);
    return n_slots;
  endfunction

endpackage

// File: rtl/dose_slot.sv
// One programmable dose slot: hour/minute/enable registers, time comparator and a
// rising-edge detector so a match held for a whole minute yields a single pulse.
module dose_slot
  import dose_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [SEC_W-1:0]  seconds,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [HOUR_W-1:0] hours,
  input  logic              cfg_wr,
  input  logic [HOUR_W-1:0] cfg_hour,
  input  logic [MIN_W-1:0]  cfg_min,
  input  logic              cfg_en,
  output logic              match_pulse
);

  logic [HOUR_W-1:0] hour_r;
  logic [MIN_W-1:0]  min_r;
  logic              en_r;
  logic              match_p0;
  logic              match_p1;

  assign match_p0    = en_r && (hours == hour_r) && (minutes == min_r) && (seconds == '0);
  assign match_pulse = match_p0 && !match_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      hour_r   <= '0;
      min_r    <= '0;
      en_r     <= 1'b0;
      match_p1 <= 1'b0;
    end else begin
      match_p1 <= match_p0;
      if (cfg_wr) begin
        hour_r <= cfg_hour;
        min_r  <= cfg_min;
        en_r   <= cfg_en;
      end
    end
  end

endmodule

// File: rtl/dose_scheduler.sv
// Programmable dose scheduler: N_SLOTS timed slots plus a manual request, arbitrated
// manual-first then lowest index; drives the motor for a pulse then a recovery gap.
// Optional per-slot completed-dose counters are enabled with DOSE_LOG_EN.
module dose_scheduler
  import dose_pkg::*;
#(
  parameter int N_SLOTS      = 3,
  parameter int PULSE_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 5000000,
  parameter int CNT_W        = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SEC_W-1:0]        seconds,
  input  logic [MIN_W-1:0]        minutes,
  input  logic [HOUR_W-1:0]       hours,
  input  logic                    cfg_we,
  input  logic [SLOT_IDX_W-1:0]   cfg_slot,
  input  logic [HOUR_W-1:0]       cfg_hour,
  input  logic [MIN_W-1:0]        cfg_min,
  input  logic                    cfg_en,
  input  logic                    manual_req,
  output logic [N_SLOTS:0]        pending,
  output logic                    motor,
  output logic                    busy,
  output logic [SLOT_IDX_W-1:0]   active_slot,
`ifdef DOSE_LOG_EN
  output logic [(N_SLOTS+1)*8-1:0] dose_count,
`endif
  output logic                    dose_done
);

  localparam int MANUAL_IDX = manual_idx(N_SLOTS);

  logic [N_SLOTS-1:0]    match_pulse;
  logic [N_SLOTS-1:0]    cfg_hit;
  logic                  manual_p1;
  logic                  manual_rise;
  logic [N_SLOTS:0]      set_vec;
  logic [N_SLOTS:0]      clr_vec;
  logic [N_SLOTS:0]      grant_vec;
  logic [SLOT_IDX_W-1:0] grant_idx;
  state_t                state;
  logic [CNT_W-1:0]      count;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    assign cfg_hit[i] = cfg_we && (int'(cfg_slot) == i);
    dose_slot u_slot (
      .clock       (clock),
      .reset       (reset),
      .seconds     (seconds),
      .minutes     (minutes),
      .hours       (hours),
      .cfg_wr      (cfg_hit[i]),
      .cfg_hour    (cfg_hour),
      .cfg_min     (cfg_min),
      .cfg_en      (cfg_en),
      .match_pulse (match_pulse[i])
    );
  end

  assign manual_rise = manual_req && !manual_p1;

  // Manual wins; otherwise the descending scan leaves the lowest set index.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    if (pending[MANUAL_IDX]) begin
      grant_vec[MANUAL_IDX] = 1'b1;
      grant_idx             = SLOT_IDX_W'(MANUAL_IDX);
    end else begin
      for (int k = N_SLOTS - 1; k >= 0; k--) begin
        if (pending[k]) begin
          grant_vec    = '0;
          grant_vec[k] = 1'b1;
          grant_idx    = SLOT_IDX_W'(k);
        end
      end
    end
  end

  // Set after clear, so a request arriving while its bit is being consumed re-arms it.
  assign set_vec = {manual_rise, match_pulse};
  assign clr_vec = {1'b0, cfg_hit} | ((state == IDLE) ? grant_vec : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= '0;
      manual_p1 <= 1'b0;
    end else begin
      pending   <= (pending & ~clr_vec) | set_vec;
      manual_p1 <= manual_req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      motor       <= 1'b0;
      busy        <= 1'b0;
      active_slot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            state       <= DISPENSE;
            active_slot <= grant_idx;
            count       <= '0;
            motor       <= 1'b1;
            busy        <= 1'b1;
          end
        end
        DISPENSE: begin
          if (count == CNT_W'(PULSE_CYCLES - 1)) begin
            state <= GAP;
            count <= '0;
            motor <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        GAP: begin
          if (count == CNT_W'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          motor <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dose_done = (state == DISPENSE) && (count == CNT_W'(PULSE_CYCLES - 1));

`ifdef DOSE_LOG_EN
  logic [N_SLOTS:0] log_clr;
  assign log_clr = {1'b0, cfg_hit};

  for (genvar k = 0; k <= N_SLOTS; k++) begin : g_log
    logic [7:0] log_cnt;
    always_ff @(posedge clock) begin
      if (reset || log_clr[k]) begin
        log_cnt <= '0;
      end else if (dose_done && (active_slot == SLOT_IDX_W'(k)) && (log_cnt != 8'hFF)) begin
        log_cnt <= log_cnt + 8'd1;
      end
    end
    assign dose_count[k*8 +: 8] = log_cnt;
  end
`endif

endmodule

// File: tb/tb_dose_scheduler.sv
// Scoreboard bench for dose_scheduler with a short pulse/gap: stimulus pushes the
// expected slot of each dose, a negedge monitor checks slot, pulse and gap lengths.
module tb_dose_scheduler;

  localparam int N_SLOTS = 3;
  localparam int PULSE   = 4;
  localparam int GAP     = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [5:0]             seconds;
  logic [5:0]             minutes;
  logic [4:0]             hours;
  logic                   cfg_we;
  logic [2:0]             cfg_slot;
  logic [4:0]             cfg_hour;
  logic [5:0]             cfg_min;
  logic                   cfg_en;
  logic                   manual_req;
  logic [N_SLOTS:0]       pending;
  logic                   motor;
  logic                   busy;
  logic [2:0]             active_slot;
  logic                   dose_done;
`ifdef DOSE_LOG_EN
  logic [(N_SLOTS+1)*8-1:0] dose_count;
`endif

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];

  dose_scheduler #(
    .N_SLOTS      (N_SLOTS),
    .PULSE_CYCLES (PULSE),
    .GAP_CYCLES   (GAP),
    .CNT_W        (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .cfg_we      (cfg_we),
    .cfg_slot    (cfg_slot),
    .cfg_hour    (cfg_hour),
    .cfg_min     (cfg_min),
    .cfg_en      (cfg_en),
    .manual_req  (manual_req),
    .pending     (pending),
    .motor       (motor),
    .busy        (busy),
    .active_slot (active_slot),
`ifdef DOSE_LOG_EN
    .dose_count  (dose_count),
`endif
    .dose_done   (dose_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
  endtask

  task automatic cfg(input int slot, input int h, input int m, input int en);
    cfg_we   = 1'b1;
    cfg_slot = 3'(slot);
    cfg_hour = 5'(h);
    cfg_min  = 6'(m);
    cfg_en   = 1'(en);
    tick(1);
    cfg_we   = 1'b0;
  endtask

  // Monitor: every completed dose must match the head of the queue, with the
  // motor on for PULSE cycles and a GAP-cycle busy/motor-off window afterwards.
  int run    = 0;
  int gapc   = 0;
  bit in_gap = 0;
  always @(negedge clock) begin
    if (reset) begin
      run    = 0;
      gapc   = 0;
      in_gap = 0;
    end else begin
      if (motor) run++;
      if (dose_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dose", 1, 0);
        end else begin
          check("dose_slot", int'(active_slot), exp_q.pop_front());
        end
        check("pulse_len", run, PULSE);
        run    = 0;
        gapc   = 0;
        in_gap = 1;
      end else if (in_gap) begin
        if (busy && !motor) begin
          gapc++;
        end else begin
          check("gap_len", gapc, GAP);
          in_gap = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    cfg_we     = 1'b0;
    cfg_slot   = '0;
    cfg_hour   = '0;
    cfg_min    = '0;
    cfg_en     = 1'b0;
    manual_req = 1'b0;
    set_time(0, 0, 30);
    tick(3);
    check("rst_pending", int'(pending), 0);
    check("rst_motor", int'(motor), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active", int'(active_slot), 0);
    check("rst_done", int'(dose_done), 0);
    reset = 1'b0;
    tick(2);

    // Single scheduled dose on slot 1 while the time holds for 10 cycles.
    cfg(1, 8, 0, 1);
    set_time(8, 0, 0);
    exp_q.push_back(1);
    tick(1);
    check("t1_pending", int'(pending), 4'b0010);
    tick(9);
    set_time(8, 0, 1);
    tick(10);
    check("t1_idle_motor", int'(motor), 0);
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_pending", int'(pending), 0);

    // Two slots at the same time: slot 0 then slot 2.
    cfg(0, 13, 0, 1);
    cfg(2, 13, 0, 1);
    set_time(13, 0, 0);
    exp_q.push_back(0);
    exp_q.push_back(2);
    tick(1);
    check("t2_pending_both", int'(pending), 4'b0101);
    tick(1);
    check("t2_pending_s2", int'(pending), 4'b0100);
    tick(5);
    check("t2_pending_wait", int'(pending), 4'b0100);
    tick(4);
    check("t2_pending_empty", int'(pending), 0);
    set_time(13, 0, 1);
    tick(10);

    // Matching time on a disabled slot does nothing.
    cfg(1, 20, 0, 0);
    set_time(20, 0, 0);
    tick(3);
    check("t3_pending", int'(pending), 0);
    check("t3_motor", int'(motor), 0);
    tick(5);
    check("t3_motor_late", int'(motor), 0);

    // Manual request during slot 0's dispense is served after the gap.
    cfg(2, 13, 0, 0);
    set_time(13, 0, 0);
    exp_q.push_back(0);
    tick(3);
    check("t4_busy", int'(busy), 1);
    check("t4_active", int'(active_slot), 0);
    manual_req = 1'b1;
    exp_q.push_back(3);
    tick(3);
    manual_req = 1'b0;
    set_time(13, 0, 1);
    tick(20);
    check("t4_idle_busy", int'(busy), 0);

    // Reset during the second dispense cycle discards the dose and slot 2's request.
    cfg(2, 13, 0, 1);
    set_time(13, 0, 0);
    tick(1);
    check("t5_pending_both", int'(pending), 4'b0101);
    tick(1);
    check("t5_motor_on", int'(motor), 1);
    tick(1);
    check("t5_pending_s2", int'(pending), 4'b0100);
    reset = 1'b1;
    set_time(13, 0, 5);
    tick(1);
    check("t5_rst_motor", int'(motor), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_pending", int'(pending), 0);
    reset = 1'b0;
    tick(20);
    check("t5_after_motor", int'(motor), 0);
    check("t5_after_busy", int'(busy), 0);

`ifdef DOSE_LOG_EN
    cfg(1, 8, 0, 1);
    for (int n = 0; n < 3; n++) begin
      set_time(8, 0, 1);
      tick(1);
      set_time(8, 0, 0);
      exp_q.push_back(1);
      tick(12);
    end
    check("log_slot1", int'(dose_count[15:8]), 3);
    cfg(1, 8, 0, 1);
    check("log_slot1_clr", int'(dose_count[15:8]), 0);
`endif

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
